// File: rtl/rtc_apb_pkg.sv
// rtl/rtc_apb_pkg.sv - shared RTC APB address map, master FSM states and response type
package rtc_apb_pkg;

    localparam int RTC_ADDR_W = 8;
    localparam int RTC_DATA_W = 32;

    // Only these three registers accept writes; reads are legal everywhere
    localparam logic [RTC_ADDR_W-1:0] RTC_ADDR_TIME  = 8'h00;
    localparam logic [RTC_ADDR_W-1:0] RTC_ADDR_ALARM = 8'h04;
    localparam logic [RTC_ADDR_W-1:0] RTC_ADDR_ADJ   = 8'h08;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

    typedef struct packed {
        logic [RTC_DATA_W-1:0] rdata;
        logic                  err;
    } rtc_rsp_t;

endpackage

// File: rtl/rtc_apb_master.sv
// rtl/rtc_apb_master.sv - single-outstanding APB requester driving the RTC slave bus
module rtc_apb_master
    import rtc_apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_cmd_ready;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [ADDR_W-1:0] r_paddr;
    logic [DATA_W-1:0] r_pwdata;
    logic              r_rsp_valid;
    rtc_rsp_t          r_rsp;

    logic              w_cmd_fire;
    logic              w_wr_unmapped;
    logic              w_access_done;

    assign w_cmd_fire    = cmd_valid && r_cmd_ready;
    assign w_wr_unmapped = cmd_write
                           && (cmd_addr != ADDR_W'(RTC_ADDR_TIME))
                           && (cmd_addr != ADDR_W'(RTC_ADDR_ALARM))
                           && (cmd_addr != ADDR_W'(RTC_ADDR_ADJ));
    // pready on the last allowed count still completes cleanly
    assign w_access_done = pready || (r_cnt == CNT_LAST);

    assign cmd_ready = r_cmd_ready;
    assign psel      = r_psel;
    assign penable   = r_penable;
    assign pwrite    = r_pwrite;
    assign paddr     = r_paddr;
    assign pwdata    = r_pwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = DATA_W'(r_rsp.rdata);
    assign rsp_err   = r_rsp.err;

    // Command/APB/response sequencer; every bus and handshake output is registered here
    always_ff @(posedge pclk or negedge preset) begin
        if (!preset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_fire) begin
                        r_cmd_ready <= 1'b0;
                        r_paddr     <= cmd_addr;
                        r_pwrite    <= cmd_write;
                        r_pwdata    <= cmd_wdata;
                        if (w_wr_unmapped) begin
                            // Rejected locally: the slave never sees this write
                            r_rsp.rdata <= '0;
                            r_rsp.err   <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_psel  <= 1'b1;
                            r_state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_access_done) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp.err   <= !pready;
                        r_rsp.rdata <= (pready && !r_pwrite) ? RTC_DATA_W'(prdata) : '0;
                        r_state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_cnt       <= '0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
